opl4_io_master: RTL
===================

# opl4_io_master

Bus-initiator counterpart of the cartridge's MSX I/O decode. It turns single byte-wide read/write requests into MSX/Z80-style I/O cycles: `msx_A`, `msx_IORQ`, `msx_RD`, `msx_WR` and a tri-state data bus. It drives the OPL4 wave ports (7Eh/7Fh) and FM ports (C4h–C7h). Optionally, before every write it polls the OPL4 status port (C4h, bit0 = BUSY). It is used as the host-side engine in FPGA ports and as the active stimulus master in cartridge benches.

## Interface
Parameters:
- SETUP_CYC, default 2: clocks with address/data valid before strobe (range 1–15).
- STROBE_CYC, default 4: clocks with IORQ and RD/WR low (range 1–15).
- HOLD_CYC, default 2: clocks with address/data held after strobe release (range 1–15).
- BUSY_POLL, default 1: 1 = poll status port C4h before each write.
- BUSY_TIMEOUT, default 255: maximum status reads per write (range 1–255).

Ports:
- clk  in  1  system clock; all outputs change only on its rising edge, except on reset.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_write  in  1  1 = I/O write, 0 = I/O read.
- req_port  in  8  I/O port address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-clock completion pulse.
- rsp_rdata  out  8  read: sampled byte; write: last status byte read (00h if no poll).
- rsp_timeout  out  1  qualifies rsp_valid; write abandoned, busy never cleared.
- msx_A  out  8  I/O address.
- msx_IORQ  out  1  active-low I/O request.
- msx_RD  out  1  active-low read strobe.
- msx_WR  out  1  active-low write strobe.
- msx_D_out  out  8  data driven on writes.
- msx_D_oe  out  1  data bus output enable.
- msx_D_in  in  8  data bus sampled on reads.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RESP. A cycle flag `is_poll` marks the current cycle as a status read of C4h.
- **IDLE:** req_ready=1. On `req_valid & req_ready`, latch port, data and write. If the request is a write and BUSY_POLL=1, set is_poll and poll_cnt=0. Then go to SETUP.
- **SETUP** (SETUP_CYC clocks):
  - msx_A = C4h if is_poll, otherwise the latched port.
  - All strobes high.
  - On a non-poll write, msx_D_out = wdata and msx_D_oe=1.
- **STROBE** (STROBE_CYC clocks):
  - msx_IORQ=0 in all cycles.
  - msx_RD=0 on reads and polls; msx_WR=0 on non-poll writes.
  - msx_D_in is captured at the edge that ends the last STROBE clock.
- **HOLD** (HOLD_CYC clocks): strobes high; msx_A, msx_D_out and msx_D_oe are held. msx_D_oe drops to 0 at the edge leaving HOLD.
- **End of a poll cycle:** poll_cnt is incremented.
  - Captured bit0=0: clear is_poll and go to SETUP for the write.
  - bit0=1 and poll_cnt<BUSY_TIMEOUT: run another poll SETUP.
  - Otherwise: go to RESP with rsp_timeout=1. No WR pulse is issued.
- **End of a non-poll cycle:** go to RESP.
- **RESP:** rsp_valid=1 for one clock, with rsp_rdata and rsp_timeout valid in that clock. Then go to IDLE. rsp_rdata and rsp_timeout hold their values until the next rsp_valid.
- Requests presented while req_ready=0 are ignored; the requester holds req_valid.
- Port value is not range-checked; any 8-bit port is cycled.
- Reads never poll.

## Timing
- Reset values: state IDLE; req_ready=1; msx_IORQ, msx_RD and msx_WR =1; msx_A=00h; msx_D_out=00h; msx_D_oe=0; rsp_valid=0; rsp_rdata=00h; rsp_timeout=0.
- Acceptance edge = E0. One bus cycle lasts C = SETUP_CYC+STROBE_CYC+HOLD_CYC clocks.
- Read, or write with BUSY_POLL=0: the cycle starts at E0, rsp_valid is high during clock E0+C to E0+C+1, and req_ready returns at E0+C+1.
- Write with BUSY_POLL=1 and N status reads (N≥1): rsp_valid at E0+(N+1)·C, or at E0+N·C on timeout.
- Defaults: C=8, so read rsp_valid at E0+8 and back-to-back request spacing is 9 clocks.
- Strobe pattern at defaults: strobe low E0+2..E0+6, released at E0+6; address and data stable E0..E0+8.
- Reset asserted mid-operation: all outputs take their reset values immediately. The request is dropped with no rsp_valid. After release the block is in IDLE.

## Test plan
- Reset, then release with no request → all outputs at reset values; req_ready=1 and stays 1; strobes high.
- Defaults, read port 7Fh, msx_D_in=A5h → msx_A=7Fh; IORQ/RD low E0+2..E0+6; WR stays 1; oe stays 0; rsp_valid at E0+8 with rsp_rdata=A5h and rsp_timeout=0.
- Defaults, write C5h←3Ch, status 00h → RD pulse at C4h (E0+2..6); then WR pulse with D_out=3Ch (E0+10..14), oe high E0+8..E0+16; rsp_valid at E0+16 with rdata=00h.
- Write 7Eh←11h, status reads 01h, 01h, 01h, then 00h → 4 RD pulses at C4h, then 1 WR pulse at 7Eh; rsp_valid at E0+40.
- BUSY_TIMEOUT=4, status always 01h, write C4h←20h → exactly 4 RD pulses and zero WR pulses; rsp_valid at E0+32 with rsp_timeout=1 and rdata=01h.
- reset_n low during STROBE → IORQ/RD/WR high and oe=0 in the same cycle; no rsp_valid; after release a new read completes normally.

Source files
------------

// File: rtl/opl4_io_master.sv
// opl4_io_master: host-side MSX/Z80-style I/O cycle engine for the OPL4 cartridge.
// Each accepted request becomes one bus cycle (SETUP, STROBE, HOLD). When BUSY_POLL
// is set, every write is preceded by status reads of port C4h until BUSY (bit0)
// clears. If BUSY never clears within BUSY_TIMEOUT reads, the write is abandoned
// and the response is flagged as a timeout.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a request, req_ready high
//   ST_SETUP  | address (and write data) valid, strobes inactive
//   ST_STROBE | IORQ low plus RD (read/poll) or WR (write) low
//   ST_HOLD   | strobes released, address/data still held
//   ST_RESP   | one-clock rsp_valid pulse
module opl4_io_master #(
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 2,
  parameter int BUSY_POLL    = 1,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_port,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic [7:0] msx_A,
  output logic       msx_IORQ,
  output logic       msx_RD,
  output logic       msx_WR,
  output logic [7:0] msx_D_out,
  output logic       msx_D_oe,
  input  logic [7:0] msx_D_in
);

  // Phase timers are down-counters loaded with length-1; a phase ends at zero.
  localparam logic [3:0] SETUP_LD    = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD   = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD     = 4'(HOLD_CYC - 1);
  localparam logic [8:0] POLL_LIMIT  = 9'(BUSY_TIMEOUT);
  localparam logic       POLL_EN     = (BUSY_POLL != 0);
  localparam logic [7:0] STATUS_PORT = 8'hC4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       is_poll, poll_nxt;
  logic [7:0] poll_cnt, poll_cnt_nxt;
  logic [8:0] poll_cnt_inc;
  logic [7:0] port_q, wdata_q, cap_q;
  logic       write_q;
  logic       accept, capture, finish, timeout_nxt;
  logic       data_phase, in_bus, strobe;

  assign poll_cnt_inc = {1'b0, poll_cnt} + 9'd1;

  // State, phase timer and poll bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      is_poll  <= 1'b0;
      poll_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      is_poll  <= poll_nxt;
      poll_cnt <= poll_cnt_nxt;
    end
  end

  // Next-state logic: phase sequencing and busy-poll decisions.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    poll_nxt     = is_poll;
    poll_cnt_nxt = poll_cnt;
    accept       = 1'b0;
    capture      = 1'b0;
    finish       = 1'b0;
    timeout_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept       = 1'b1;
          state_nxt    = ST_SETUP;
          cnt_nxt      = SETUP_LD;
          poll_nxt     = req_write & POLL_EN;
          poll_cnt_nxt = 8'd0;
        end
      end
      ST_SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt == 4'd0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = HOLD_LD;
          // Write-strobe bus data is never captured so cap_q keeps the last status.
          capture   = ~data_phase;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (is_poll) begin
          poll_cnt_nxt = poll_cnt_inc[7:0];
          if (!cap_q[0]) begin
            poll_nxt  = 1'b0;
            state_nxt = ST_SETUP;
            cnt_nxt   = SETUP_LD;
          end else if (poll_cnt_inc < POLL_LIMIT) begin
            state_nxt = ST_SETUP;
            cnt_nxt   = SETUP_LD;
          end else begin
            poll_nxt    = 1'b0;
            state_nxt   = ST_RESP;
            finish      = 1'b1;
            timeout_nxt = 1'b1;
          end
        end else begin
          state_nxt = ST_RESP;
          finish    = 1'b1;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request latch, read-data capture and sticky response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q      <= 8'h00;
      wdata_q     <= 8'h00;
      write_q     <= 1'b0;
      cap_q       <= 8'h00;
      rsp_rdata   <= 8'h00;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        port_q  <= req_port;
        wdata_q <= req_wdata;
        write_q <= req_write;
      end
      if (capture) begin
        cap_q <= msx_D_in;
      end
      if (finish) begin
        // Unpolled writes report 00h; polled writes report the last status byte.
        rsp_rdata   <= (write_q && !POLL_EN) ? 8'h00 : cap_q;
        rsp_timeout <= timeout_nxt;
      end
    end
  end

  assign data_phase = write_q & ~is_poll;
  assign in_bus     = (state == ST_SETUP) || (state == ST_STROBE) || (state == ST_HOLD);
  assign strobe     = (state == ST_STROBE);

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign msx_A      = is_poll ? STATUS_PORT : port_q;
  assign msx_IORQ   = ~strobe;
  assign msx_RD     = ~(strobe & ~data_phase);
  assign msx_WR     = ~(strobe & data_phase);
  assign msx_D_out  = wdata_q;
  assign msx_D_oe   = in_bus & data_phase;

endmodule
